// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bundle bit layout,
// bundle width helper and the per-edge action encoding.
package id_ex_pkg;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMTOREG  = 1;
   localparam int CTRL_BRANCH    = 2;
   localparam int CTRL_MEMREAD   = 3;
   localparam int CTRL_MEMWRITE  = 4;
   localparam int CTRL_ALUSRC    = 5;
   localparam int CTRL_REGDST    = 6;
   localparam int CTRL_ALUOP_LSB = 7;

   function automatic int ctrl_w(input int aluop_w);
      return 7 + aluop_w;
   endfunction

   // Wide enough for any ALUop width; slice down to CTRL_W at the use site.
   localparam logic [63:0] CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      ACT_HOLD   = 2'd0,
      ACT_FLUSH  = 2'd1,
      ACT_BUBBLE = 2'd2,
      ACT_LOAD   = 2'd3
   } act_e;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX bus: decode-side fields in, execute-side fields out, plus stall/flush
// control and the bubble counter. slave = the pipeline register.
interface id_ex_pipe_reg_if
   import id_ex_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 2,
   parameter int CNT_W      = 16
);
   localparam int CTRL_W = ctrl_w(ALUOP_W);

   logic                  hold_i, flush_i, valid_in, rt_used_in;
   logic [CTRL_W-1:0]     ctrl_in;
   logic [DATA_W-1:0]     pc4_in, rd1_in, rd2_in, imm_in;
   logic [REG_ADDR_W-1:0] rs_in, rt_in, rd_in;

   logic                  valid_out, stall_o;
   logic [CTRL_W-1:0]     ctrl_out;
   logic [DATA_W-1:0]     pc4_out, rd1_out, rd2_out, imm_out;
   logic [REG_ADDR_W-1:0] rs_out, rt_out, rd_out;
   logic [CNT_W-1:0]      bubble_cnt_o;

   modport master (
      output hold_i, flush_i, valid_in, rt_used_in, ctrl_in,
             pc4_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in,
      input  valid_out, stall_o, ctrl_out, pc4_out, rd1_out, rd2_out, imm_out,
             rs_out, rt_out, rd_out, bubble_cnt_o
   );

   modport slave (
      input  hold_i, flush_i, valid_in, rt_used_in, ctrl_in,
             pc4_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in,
      output valid_out, stall_o, ctrl_out, pc4_out, rd1_out, rd2_out, imm_out,
             rs_out, rt_out, rd_out, bubble_cnt_o
   );

endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard: a valid load in EX whose destination Rt is
// read by the valid instruction in ID. Writes to $0 never hazard.
module load_use_detect #(
   parameter int ENABLE     = 1,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  valid_ex,
   input  logic                  memread_ex,
   input  logic [REG_ADDR_W-1:0] rt_ex,
   input  logic                  valid_id,
   input  logic                  rt_used_id,
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   output logic                  hazard
);
   logic en;
   logic src_match;

   assign en        = (ENABLE != 0);
   assign src_match = (rt_ex == rs_id) | (rt_used_id & (rt_ex == rt_id));
   assign hazard    = en & valid_ex & memread_ex & (rt_ex != '0) & valid_id & src_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold/flush, load-use bubble insertion and a
// saturating bubble counter.
module id_ex_pipe_reg
   import id_ex_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int REG_ADDR_W    = 5,
   parameter int ALUOP_W       = 2,
   parameter int ENABLE_HAZARD = 1,
   parameter int CNT_W         = 16
) (
   input logic             clk,
   input logic             rst,
   id_ex_pipe_reg_if.slave bus
);
   localparam int CTRL_W = ctrl_w(ALUOP_W);

   logic                  valid_q;
   logic [CTRL_W-1:0]     ctrl_q;
   logic [DATA_W-1:0]     pc4_q, rd1_q, rd2_q, imm_q;
   logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  hazard;
   act_e                  act;

   load_use_detect #(.ENABLE(ENABLE_HAZARD), .REG_ADDR_W(REG_ADDR_W)) u_lud (
      .valid_ex   (valid_q),
      .memread_ex (ctrl_q[CTRL_MEMREAD]),
      .rt_ex      (rt_q),
      .valid_id   (bus.valid_in),
      .rt_used_id (bus.rt_used_in),
      .rs_id      (bus.rs_in),
      .rt_id      (bus.rt_in),
      .hazard     (hazard)
   );

   // A flush already kills the ID slot, so it must not also freeze the front end.
   assign bus.stall_o = bus.hold_i | (hazard & ~bus.flush_i);

   always_comb begin
      act = ACT_LOAD;
      if (bus.hold_i)       act = ACT_HOLD;
      else if (bus.flush_i) act = ACT_FLUSH;
      else if (hazard)      act = ACT_BUBBLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pc4_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else if (act != ACT_HOLD) begin
         pc4_q <= bus.pc4_in;
         rd1_q <= bus.rd1_in;
         rd2_q <= bus.rd2_in;
         imm_q <= bus.imm_in;
         rs_q  <= bus.rs_in;
         rt_q  <= bus.rt_in;
         rd_q  <= bus.rd_in;
         if (act == ACT_LOAD) begin
            valid_q <= bus.valid_in;
            ctrl_q  <= bus.valid_in ? bus.ctrl_in : CTRL_BUBBLE[CTRL_W-1:0];
         end else begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE[CTRL_W-1:0];
         end
         if (act == ACT_BUBBLE && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.valid_out    = valid_q;
   assign bus.ctrl_out     = ctrl_q;
   assign bus.pc4_out      = pc4_q;
   assign bus.rd1_out      = rd1_q;
   assign bus.rd2_out      = rd2_q;
   assign bus.imm_out      = imm_q;
   assign bus.rs_out       = rs_q;
   assign bus.rt_out       = rt_q;
   assign bus.rd_out       = rd_q;
   assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed + random bench for id_ex_pipe_reg: a spec-level model pushes the
// expected EX slot to a queue each cycle; it is popped after the edge.
module tb_id_ex_pipe_reg;
   import id_ex_pkg::*;

   localparam int CW = ctrl_w(2);
   localparam logic [CW-1:0] LW   = 9'h02B;  // ALUSrc, MemRead, MemtoReg, RegWrite
   localparam logic [CW-1:0] ADD  = 9'h141;  // ALUop=10, RegDst, RegWrite
   localparam logic [CW-1:0] ADDI = 9'h021;  // ALUSrc, RegWrite

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          hold, flush, vin, rtu;
   logic [CW-1:0] ctrl;
   logic [31:0]   pc4, rd1, rd2, imm;
   logic [4:0]    rs, rt, rd;

   id_ex_pipe_reg_if                     if_main ();
   id_ex_pipe_reg_if #(.CNT_W(2))        if_sat ();
   id_ex_pipe_reg_if                     if_noh ();

   id_ex_pipe_reg                        u_main (.clk(clk), .rst(rst), .bus(if_main));
   id_ex_pipe_reg #(.CNT_W(2))           u_sat  (.clk(clk), .rst(rst), .bus(if_sat));
   id_ex_pipe_reg #(.ENABLE_HAZARD(0))   u_noh  (.clk(clk), .rst(rst), .bus(if_noh));

   assign if_main.hold_i = hold;  assign if_main.flush_i = flush; assign if_main.valid_in = vin;
   assign if_main.rt_used_in = rtu; assign if_main.ctrl_in = ctrl; assign if_main.pc4_in = pc4;
   assign if_main.rd1_in = rd1;   assign if_main.rd2_in = rd2;    assign if_main.imm_in = imm;
   assign if_main.rs_in = rs;     assign if_main.rt_in = rt;      assign if_main.rd_in = rd;
   assign if_sat.hold_i = hold;   assign if_sat.flush_i = flush;  assign if_sat.valid_in = vin;
   assign if_sat.rt_used_in = rtu; assign if_sat.ctrl_in = ctrl;  assign if_sat.pc4_in = pc4;
   assign if_sat.rd1_in = rd1;    assign if_sat.rd2_in = rd2;     assign if_sat.imm_in = imm;
   assign if_sat.rs_in = rs;      assign if_sat.rt_in = rt;       assign if_sat.rd_in = rd;
   assign if_noh.hold_i = hold;   assign if_noh.flush_i = flush;  assign if_noh.valid_in = vin;
   assign if_noh.rt_used_in = rtu; assign if_noh.ctrl_in = ctrl;  assign if_noh.pc4_in = pc4;
   assign if_noh.rd1_in = rd1;    assign if_noh.rd2_in = rd2;     assign if_noh.imm_in = imm;
   assign if_noh.rs_in = rs;      assign if_noh.rt_in = rt;       assign if_noh.rd_in = rd;

   typedef struct {
      logic          v;
      logic [CW-1:0] ctrl;
      logic [31:0]   pc4, rd1, rd2, imm;
      logic [4:0]    rs, rt, rd;
      logic [15:0]   cnt;
   } exp_t;

   exp_t m;
   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_haz();
      return m.v & m.ctrl[CTRL_MEMREAD] & (m.rt != 0) & vin &
             ((m.rt == rs) | (rtu & (m.rt == rt)));
   endfunction

   task automatic set_in(input logic v, input logic u, input logic [CW-1:0] c,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      vin = v; rtu = u; ctrl = c; rs = s; rt = t; rd = d;
      pc4 = $urandom; rd1 = $urandom; rd2 = $urandom; imm = $urandom;
   endtask

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, "_valid"}, 64'(if_main.valid_out), 64'(e.v));
      chk({tag, "_ctrl"},  64'(if_main.ctrl_out), 64'(e.ctrl));
      chk({tag, "_pc4"},   64'(if_main.pc4_out), 64'(e.pc4));
      chk({tag, "_rd12"},  {if_main.rd1_out, if_main.rd2_out}, {e.rd1, e.rd2});
      chk({tag, "_imm"},   64'(if_main.imm_out), 64'(e.imm));
      chk({tag, "_regs"},  64'({if_main.rs_out, if_main.rt_out, if_main.rd_out}), 64'({e.rs, e.rt, e.rd}));
      chk({tag, "_cnt"},   64'(if_main.bubble_cnt_o), 64'(e.cnt));
   endtask

   // One clock: check combinational stall, predict the EX slot, compare after the edge.
   task automatic step(input string tag);
      exp_t e;
      logic hz;
      #1;
      hz = model_haz();
      chk({tag, "_stall"}, 64'(if_main.stall_o), 64'(hold | (hz & ~flush)));
      chk({tag, "_noh_stall"}, 64'(if_noh.stall_o), 64'(hold));
      e = m;
      if (!hold) begin
         e.pc4 = pc4; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
         e.rs = rs; e.rt = rt; e.rd = rd;
         if (flush || hz) begin
            e.v = 1'b0; e.ctrl = '0;
            if (!flush && e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
         end else begin
            e.v = vin; e.ctrl = vin ? ctrl : '0;
         end
      end
      q.push_back(e);
      m = e;
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk_out(tag, e);
   endtask

   // Mid-cycle reset pulse; outputs must clear before the next edge.
   task automatic rst_pulse(input string tag);
      #1;
      chk({tag, "_pre_stall"}, 64'(if_main.stall_o), 64'(hold | (model_haz() & ~flush)));
      rst = 1'b1;
      #1;
      chk({tag, "_valid0"}, 64'(if_main.valid_out), 64'd0);
      chk({tag, "_ctrl0"},  64'(if_main.ctrl_out), 64'd0);
      chk({tag, "_data0"},  {if_main.pc4_out | if_main.rd1_out, if_main.rd2_out | if_main.imm_out}, 64'd0);
      chk({tag, "_regs0"},  64'({if_main.rs_out, if_main.rt_out, if_main.rd_out}), 64'd0);
      chk({tag, "_cnt0"},   64'({if_main.bubble_cnt_o, if_sat.bubble_cnt_o}), 64'd0);
      chk({tag, "_stall0"}, 64'(if_main.stall_o), 64'd0);
      #1;
      rst = 1'b0;
      m = '{default: '0};
      q.delete();
   endtask

   initial begin
      hold = 0; flush = 0;
      set_in(0, 0, '0, 0, 0, 0);
      rst = 1'b1;
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // Reset with all inputs nonzero after a real load.
      set_in(1, 1, 9'h1FF, 5'd31, 5'd30, 5'd29);
      step("t1_load");
      rst_pulse("t1_rst");

      // lw $t0 then add using $t0: one bubble, then add enters EX intact.
      set_in(1, 1, LW, 5'd9, 5'd8, 5'd0);
      step("t2_lw");
      set_in(1, 1, ADD, 5'd8, 5'd10, 5'd11);
      step("t2_bubble");
      chk("t2_bubble_valid", 64'(if_main.valid_out), 64'd0);
      chk("t2_bubble_cnt", 64'(if_main.bubble_cnt_o), 64'd1);
      step("t2_add");
      chk("t2_add_ctrl", 64'(if_main.ctrl_out), 64'(ADD));

      // lw to $0 never hazards; unused Rt does not hazard.
      set_in(1, 1, LW, 5'd1, 5'd0, 5'd0);
      step("t3_lw0");
      set_in(1, 1, ADD, 5'd0, 5'd0, 5'd5);
      step("t3_rd0");
      chk("t3_cnt_same", 64'(if_main.bubble_cnt_o), 64'd1);
      set_in(1, 0, LW, 5'd2, 5'd8, 5'd0);
      step("t3_lw8");
      set_in(1, 0, ADDI, 5'd3, 5'd8, 5'd0);
      step("t3_itype");
      chk("t3_itype_valid", 64'(if_main.valid_out), 64'd1);

      // Flush coinciding with a hazard, then a 3-cycle hold.
      set_in(1, 1, LW, 5'd4, 5'd8, 5'd0);
      step("t4_lw");
      set_in(1, 1, ADD, 5'd8, 5'd8, 5'd12);
      flush = 1;
      step("t4_flush");
      chk("t4_flush_cnt", 64'(if_main.bubble_cnt_o), 64'd1);
      flush = 0;
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 9'(i + 3), 5'(i + 1), 5'(i + 2), 5'(i + 3));
         step("t4_hold");
      end
      hold = 0;

      // Reset while the front end is stalled; the next edge is a normal load.
      set_in(1, 1, LW, 5'd4, 5'd8, 5'd0);
      step("rs_lw");
      set_in(1, 1, ADD, 5'd8, 5'd9, 5'd13);
      rst_pulse("rs_rst");
      step("rs_load");
      chk("rs_load_valid", 64'(if_main.valid_out), 64'd1);

      // Five back-to-back load-use pairs: 2-bit counter saturates, disabled detector never counts.
      rst_pulse("t5_rst");
      for (int i = 0; i < 5; i++) begin
         set_in(1, 1, LW, 5'd1, 5'd8, 5'd0);
         step("t5_lw");
         set_in(1, 1, ADD, 5'd8, 5'd2, 5'd3);
         step("t5_add");
         step("t5_add2");
      end
      chk("t5_sat_cnt", 64'(if_sat.bubble_cnt_o), 64'd3);
      chk("t5_noh_cnt", 64'(if_noh.bubble_cnt_o), 64'd0);
      chk("t5_main_cnt", 64'(if_main.bubble_cnt_o), 64'd5);

      // Random mix with a narrow register range to provoke hazards.
      for (int i = 0; i < 40; i++) begin
         hold  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         set_in(1'($urandom), 1'($urandom),
                ($urandom_range(0, 1) != 0) ? LW : CW'($urandom),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
